// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake with a two-entry skid buffer, so in_ready is a flop.
// Optional saturating stall counter enabled by defining PIPE_STALL_CNT_EN.
module pipe_stage_reg #(
    parameter int WIDTH      = 64,
    parameter int CLEAR_DATA = 1,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
`ifdef PIPE_STALL_CNT_EN
    ,
    output logic [CNT_W-1:0] stall_cnt
`endif
);

    // Handshake: a transfer happens on a rising edge where valid and ready are both high;
    // valid never depends on ready, and ready depends only on registered state.

    // Encoding is {skid_valid, main_valid}, so in_ready is a direct flop output.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } occ_e;

    occ_e             state;
    occ_e             state_nxt;
    logic             in_fire;
    logic             out_fire;
    logic             load_main_in;
    logic             load_main_skid;
    logic             load_skid;
    logic [WIDTH-1:0] main_data;
    logic [WIDTH-1:0] skid_data;

    if (CNT_W < 1) begin : g_cnt_w_check
        $error("CNT_W must be at least 1");
    end

    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt      = state;
        load_main_in   = 1'b0;
        load_main_skid = 1'b0;
        load_skid      = 1'b0;
        case (state)
            ST_EMPTY: begin
                if (in_fire) begin
                    load_main_in = 1'b1;
                    state_nxt    = ST_ONE;
                end
            end
            ST_ONE: begin
                if (in_fire && out_fire) begin
                    load_main_in = 1'b1;
                end else if (in_fire) begin
                    load_skid = 1'b1;
                    state_nxt = ST_TWO;
                end else if (out_fire) begin
                    state_nxt = ST_EMPTY;
                end
            end
            ST_TWO: begin
                // in_ready is low here, so only the drain side can move.
                if (out_fire) begin
                    load_main_skid = 1'b1;
                    state_nxt      = ST_ONE;
                end
            end
            default: state_nxt = ST_EMPTY;
        endcase
    end

    always_comb begin
        in_ready  = ~state[1];
        out_valid = state[0];
        out_data  = main_data;
    end

    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            if (CLEAR_DATA != 0) begin
                main_data <= '0;
                skid_data <= '0;
            end
        end else begin
            if (load_main_in) begin
                main_data <= in_data;
            end else if (load_main_skid) begin
                main_data <= skid_data;
            end
            if (load_skid) begin
                skid_data <= in_data;
            end
        end
    end

`ifdef PIPE_STALL_CNT_EN
    // Survives flush on purpose: it measures stall pressure across bubbles.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            stall_cnt <= '0;
        end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: doc/pipe_stage_reg.md
# pipe_stage_reg

Parametrised pipeline stage register with a valid/ready handshake and a two-entry skid buffer. Used between any two CPU pipeline stages (F/D, D/E, E/M, M/W) in place of fixed per-stage registers. Accepts one payload per cycle at full throughput, and absorbs a single-cycle downstream stall without a combinational ready path. A synchronous flush turns the stage into a bubble.

## Interface
Parameters:
- WIDTH, 64 — payload width in bits (e.g. instruction word + PC+4).
- CLEAR_DATA, 1 — 1: payload registers are zeroed on reset/flush (NOP = 0); 0: payload registers hold their value and only valid bits clear.
- CNT_W, 16 — width of the stall counter (only used when PIPE_STALL_CNT_EN is defined).

Ports:
- clk  in  1  — sole clock; all state changes on the rising edge.
- reset_n  in  1  — synchronous, active-low reset.
- flush  in  1  — synchronous clear of all stage contents.
- in_valid  in  1  — upstream presents a payload.
- in_ready  out  1  — stage can accept; driven directly from a register (no input-to-output combinational path).
- in_data  in  WIDTH  — upstream payload.
- out_valid  out  1  — stage holds a valid payload.
- out_ready  in  1  — downstream consumes this cycle.
- out_data  out  WIDTH  — payload at the head of the stage.
- stall_cnt  out  CNT_W  — saturating count of stalled cycles; present only with PIPE_STALL_CNT_EN.

## Operation
- Storage: main entry (drives out_data/out_valid) and skid entry, each with a valid bit.
- Fire rules: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = !skid_valid.
- Occupancy states and transitions:
  - EMPTY: in_fire → main ← in_data, go to ONE.
  - ONE:
    - in_fire & out_fire → main ← in_data, stay in ONE.
    - in_fire only → skid ← in_data, go to TWO.
    - out_fire only → go to EMPTY.
  - TWO: in_ready = 0. out_fire → main ← skid, go to ONE.
- Order is strictly FIFO. No payload is dropped or duplicated except on flush.
- flush has priority over every handshake in the same cycle:
  - both valid bits clear.
  - A simultaneous in_fire is discarded.
  - A simultaneous out_fire is still seen by downstream, because out_data is valid in that cycle.
  - With CLEAR_DATA=1, both payload registers are zeroed.
- reset_n = 0 has priority over flush and has the same effect. CLEAR_DATA=1 zeroes the data.
- in_data is sampled only on in_fire. It may change freely otherwise.

## Timing
- Reset values:
  - out_valid = 0
  - in_ready = 1 (from the first edge after reset)
  - out_data = 0 when CLEAR_DATA=1
  - stall_cnt = 0
- Latency: a payload accepted at edge N is on out_data with out_valid = 1 after edge N (one cycle).
- Throughput: one transfer per cycle when out_ready stays high.
- Downstream stall of one cycle: stage goes to TWO, in_ready drops the following cycle, and no data is lost.
- Minimum recovery: TWO → ONE on the first out_fire. in_ready returns high the cycle after that.
- Flush at edge N: out_valid = 0 and in_ready = 1 after edge N. A new payload can be accepted at edge N+1.
- When reset_n or flush is deasserted mid-stream, the stage starts from EMPTY. No stale payload reappears.

## Configuration
- PIPE_STALL_CNT_EN, when defined:
  - stall_cnt increments on each cycle where out_valid & !out_ready.
  - It saturates at 2^CNT_W−1.
  - It is cleared only by reset_n, not by flush.
- Without the macro: the stall_cnt port and its counter logic are absent. Handshake behaviour is identical.

## Test plan
- Reset then stream: reset_n = 0 for 2 cycles, then in_valid = 1 with data 1, 2, 3, 4 on consecutive cycles and out_ready = 1 → out_data = 1, 2, 3, 4 one cycle later each, and in_ready stays 1.
- Skid absorb:
  - Stimulus: stream 0xA, 0xB, 0xC with out_ready = 0 for one cycle after 0xA appears.
  - Required: in_ready = 0 for exactly one cycle, and the output order is 0xA, 0xB, 0xC with none lost.
- Full hold: fill to TWO (0x11 in main, 0x22 in skid), then hold out_ready = 0 for 5 cycles while in_valid = 1 with 0x33 → out_data stays 0x11, in_ready = 0, and 0x33 is accepted only after out_ready rises.
- Flush with simultaneous input:
  - Stimulus: assert flush in a cycle where in_valid = 1 with data 0x55 and the stage is in TWO.
  - Required next cycle: out_valid = 0, in_ready = 1, out_data = 0 (CLEAR_DATA=1), and 0x55 never appears at the output.
- Reset priority: assert flush and reset_n = 0 together mid-stream → same cleared state. With PIPE_STALL_CNT_EN, stall_cnt = 0.
- Stall counter (PIPE_STALL_CNT_EN, CNT_W = 4): hold out_valid = 1 and out_ready = 0 for 20 cycles → stall_cnt = 15 (saturated). A subsequent flush leaves it at 15.
